// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/sub ops, bit-serial shift-add multiply,
// and one-bit-per-cycle shifts, with a registered result and flags.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_FWD = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_SUB = 3'b100, OP_MUL = 3'b101, OP_SLL = 3'b110, OP_SRA = 3'b111
    } op_e;

    typedef enum logic {IDLE, EXEC} state_e;

    state_e             state, state_next;
    op_e                op_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;     // product accumulator; low half doubles as shift operand
    logic [CW-1:0]      cnt_q;

    logic [SHW-1:0]     amt;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   diff_c;
    logic [WIDTH-1:0]   res_c;
    logic               carry_c, ovf_c, multi_c;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   sll_val, sra_val;
    logic               last;

    assign amt      = data2[SHW-1:0];
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign sll_val  = {acc_q[WIDTH-2:0], 1'b0};
    assign sra_val  = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    assign last     = (cnt_q == CW'(1));
    assign busy     = (state == EXEC);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        multi_c = 1'b0;
        sum_c   = {1'b0, data1} + {1'b0, data2};
        diff_c  = data1 - data2;
        case (op_e'(select))
            OP_FWD: res_c = data2;
            OP_ADD: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum_c[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_AND: res_c = data1 & data2;
            OP_OR:  res_c = data1 | data2;
            OP_SUB: begin
                res_c   = diff_c;
                carry_c = (data1 < data2);
                ovf_c   = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff_c[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_MUL: multi_c = 1'b1;
            default: begin
                if (amt == '0) res_c = data1;
                else           multi_c = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && multi_c) state_next = EXEC;
            EXEC:    if (last)             state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: operand and counter registers are reset too, so an aborted operation leaves no residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= OP_FWD;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result   <= '0;
            zero     <= 1'b1;
            carry    <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    op_q <= op_e'(select);
                    if (!multi_c) begin
                        result   <= res_c;
                        zero     <= (res_c == '0);
                        carry    <= carry_c;
                        overflow <= ovf_c;
                        done     <= 1'b1;
                    end else begin
                        mcand_q  <= {{WIDTH{1'b0}}, data1};
                        mplier_q <= data2;
                        if (op_e'(select) == OP_MUL) begin
                            acc_q <= '0;
                            cnt_q <= CW'(WIDTH);
                        end else begin
                            acc_q <= {{WIDTH{1'b0}}, data1};
                            cnt_q <= CW'(amt);
                        end
                    end
                end
            end else begin
                cnt_q <= cnt_q - CW'(1);
                case (op_q)
                    OP_MUL: begin
                        acc_q    <= acc_step;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        if (last) begin
                            result   <= acc_step[WIDTH-1:0];
                            zero     <= (acc_step[WIDTH-1:0] == '0);
                            carry    <= |acc_step[2*WIDTH-1:WIDTH];
                            overflow <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    OP_SLL: begin
                        acc_q[WIDTH-1:0] <= sll_val;
                        if (last) begin
                            result   <= sll_val;
                            zero     <= (sll_val == '0);
                            carry    <= acc_q[WIDTH-1];
                            overflow <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    OP_SRA: begin
                        acc_q[WIDTH-1:0] <= sra_val;
                        if (last) begin
                            result   <= sra_val;
                            zero     <= (sra_val == '0);
                            carry    <= acc_q[0];
                            overflow <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8): table of single/multi-cycle ops
// plus hand sequences for busy-ignore, back-to-back issue and mid-op reset.
module tb_alu_seq;

    localparam int W = 8;
    localparam logic [2:0] OP_FWD = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                           OP_SUB = 3'b100, OP_MUL = 3'b101, OP_SLL = 3'b110, OP_SRA = 3'b111;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         v;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   select;
    logic [W-1:0] data1, data2, result;
    logic         busy, done, zero, carry, overflow;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t vecs[17];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .select(select),
        .data1(data1), .data2(data2), .result(result), .busy(busy),
        .done(done), .zero(zero), .carry(carry), .overflow(overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, nb;
        @(negedge clk);
        start = 1'b1; select = v.op; data1 = v.a; data2 = v.b;
        @(posedge clk); #1;
        start = 1'b0; select = ~v.op; data1 = ~v.a; data2 = ~v.b;
        n = 1; nb = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("v%0d latency", idx), n, v.lat);
        check($sformatf("v%0d busy cycles", idx), nb, v.lat - 1);
        check($sformatf("v%0d result", idx), result, v.res);
        check($sformatf("v%0d carry", idx), carry, v.c);
        check($sformatf("v%0d overflow", idx), overflow, v.v);
        check($sformatf("v%0d zero", idx), zero, (v.res == 0));
        check($sformatf("v%0d busy at done", idx), busy, 0);
        @(posedge clk); #1;
        check($sformatf("v%0d done pulse width", idx), done, 0);
    endtask

    initial begin
        logic [W-1:0] prev, got;
        int           ndone, done_cyc, stable;

        reset = 1'b1; start = 1'b0; select = '0; data1 = '0; data2 = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result, 0);
        check("reset zero", zero, 1);
        check("reset carry", carry, 0);
        check("reset overflow", overflow, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge clk) reset = 1'b1;

        vecs[0]  = '{OP_ADD, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 1};
        vecs[1]  = '{OP_SUB, 8'd5,   8'd7,   8'd254, 1'b1, 1'b0, 1};
        vecs[2]  = '{OP_SUB, 8'd127, 8'd255, 8'd128, 1'b1, 1'b1, 1};
        vecs[3]  = '{OP_MUL, 8'd15,  8'd17,  8'd255, 1'b0, 1'b0, 9};
        vecs[4]  = '{OP_MUL, 8'd16,  8'd16,  8'd0,   1'b1, 1'b0, 9};
        vecs[5]  = '{OP_SRA, 8'h80,  8'd3,   8'hF0,  1'b0, 1'b0, 4};
        vecs[6]  = '{OP_SLL, 8'h81,  8'd1,   8'h02,  1'b1, 1'b0, 2};
        vecs[7]  = '{OP_FWD, 8'h11,  8'hA5,  8'hA5,  1'b0, 1'b0, 1};
        vecs[8]  = '{OP_AND, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 1};
        vecs[9]  = '{OP_OR,  8'hF0,  8'h0F,  8'hFF,  1'b0, 1'b0, 1};
        vecs[10] = '{OP_ADD, 8'd100, 8'd50,  8'd150, 1'b0, 1'b1, 1};
        vecs[11] = '{OP_SLL, 8'h55,  8'h08,  8'h55,  1'b0, 1'b0, 1};
        vecs[12] = '{OP_SRA, 8'h7F,  8'd7,   8'h00,  1'b1, 1'b0, 8};
        vecs[13] = '{OP_SUB, 8'd10,  8'd10,  8'd0,   1'b0, 1'b0, 1};
        vecs[14] = '{OP_MUL, 8'd255, 8'd255, 8'h01,  1'b1, 1'b0, 9};
        vecs[15] = '{OP_SRA, 8'h96,  8'd2,   8'hE5,  1'b1, 1'b0, 3};
        vecs[16] = '{OP_ADD, 8'h80,  8'h80,  8'h00,  1'b1, 1'b1, 1};

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // START pulsed mid-MUL must be ignored; result held until the single DONE
        prev = result;
        @(negedge clk);
        start = 1'b1; select = OP_MUL; data1 = 8'd15; data2 = 8'd17;
        @(posedge clk); #1;
        ndone = 0; done_cyc = -1; stable = 1; got = '0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            start  = (cyc == 3);
            select = (cyc == 3) ? OP_ADD : OP_MUL;
            data1  = (cyc == 3) ? 8'd1 : 8'd0;
            data2  = (cyc == 3) ? 8'd1 : 8'd0;
            @(posedge clk); #1;
            if (done) begin
                ndone++; done_cyc = cyc; got = result;
            end else if (ndone == 0 && result !== prev) begin
                stable = 0;
            end
        end
        check("busy-ignore done count", ndone, 1);
        check("busy-ignore done cycle", done_cyc, 8);
        check("busy-ignore result", got, 255);
        check("busy-ignore result held", stable, 1);

        // back-to-back single-cycle issue
        @(negedge clk);
        start = 1'b1; select = OP_ADD; data1 = 8'd1; data2 = 8'd2;
        @(posedge clk); #1;
        check("b2b first done", done, 1);
        check("b2b first result", result, 3);
        @(negedge clk);
        select = OP_SUB; data1 = 8'd9; data2 = 8'd4;
        @(posedge clk); #1;
        check("b2b second done", done, 1);
        check("b2b second result", result, 5);
        @(negedge clk) start = 1'b0;
        @(posedge clk); #1;
        check("b2b idle done", done, 0);

        // START in the DONE cycle of a multi-cycle shift
        @(negedge clk);
        start = 1'b1; select = OP_SLL; data1 = 8'h81; data2 = 8'd1;
        @(posedge clk); #1;
        check("shift busy", busy, 1);
        @(negedge clk) start = 1'b0;
        @(posedge clk); #1;
        check("shift done", done, 1);
        check("shift result", result, 8'h02);
        @(negedge clk);
        start = 1'b1; select = OP_FWD; data1 = 8'h00; data2 = 8'h3C;
        @(posedge clk); #1;
        check("done-cycle issue done", done, 1);
        check("done-cycle issue result", result, 8'h3C);
        @(negedge clk) start = 1'b0;

        // reset during MUL aborts it
        @(negedge clk);
        start = 1'b1; select = OP_MUL; data1 = 8'd15; data2 = 8'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        check("abort result", result, 0);
        check("abort zero", zero, 1);
        check("abort carry", carry, 0);
        check("abort overflow", overflow, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        @(negedge clk) reset = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort no done", ndone, 0);

        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; start = 1'b1; select = OP_ADD; data1 = 8'd3; data2 = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("post-reset done", done, 1);
        check("post-reset result", result, 7);
        check("post-reset carry", carry, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
